// File: rtl/fredkin_alu_sequencer_if.sv
// fredkin_alu_sequencer_if: ALU request/response handshake plus Fredkin array port bundle.
interface fredkin_alu_sequencer_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] req_c;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;
    logic [WIDTH-1:0] fk_a;
    logic [WIDTH-1:0] fk_b;
    logic [WIDTH-1:0] fk_c;
    logic [WIDTH-1:0] fk_p;
    logic [WIDTH-1:0] fk_q;
    logic [WIDTH-1:0] fk_r;

    modport master (
        output req_valid, req_op, req_a, req_b, req_c, resp_ready, fk_p, fk_q, fk_r,
        input  req_ready, resp_valid, resp_data, resp_err, fk_a, fk_b, fk_c
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_c, resp_ready, fk_p, fk_q, fk_r,
        output req_ready, resp_valid, resp_data, resp_err, fk_a, fk_b, fk_c
    );
endinterface

// File: rtl/fredkin_alu_sequencer.sv
// fredkin_alu_sequencer: runs 8 bitwise ALU ops as 1-2 passes through a shared Fredkin gate array.
module fredkin_alu_sequencer #(
    parameter int WIDTH      = 32,
    parameter int FK_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fredkin_alu_sequencer_if.slave        bus,
    output logic                          busy,
    output logic [7:0]                    err_count
);
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
    localparam logic [3:0] LAST = 4'(FK_LATENCY - 1);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state, state_n;
    logic [2:0]       op, op_n;
    logic [WIDTH-1:0] a, a_n, b, b_n;
    logic             pass, pass_n;
    logic [3:0]       cnt, cnt_n;
    logic             err, err_n;
    logic             rdy;
    logic [WIDTH-1:0] fa, fb, fc, fa_n, fb_n, fc_n;
    logic [WIDTH-1:0] data, data_n;
    logic [7:0]       ec_n;
    logic [WIDTH-1:0] sel;
    logic             last, mism;

    // Fredkin: P=A, Q=A?C:B, R=A?B:C; returns {A,B,C} for a given op and pass
    function automatic logic [3*WIDTH-1:0] operands(input logic [2:0] o, input logic p,
                                                    input logic [WIDTH-1:0] x, y, z, t);
        if (p)
            return (o == 3'd4) ? {y, x, t} : (o == 3'd5) ? {y, t, x} : {t, ONES, ZERO};
        return (o == 3'd3) ? {z, y, x}
             : (o == 3'd2 || o[2:1] == 2'b10) ? {x, ONES, ZERO}
             : {x, y, (o == 3'd1 || o == 3'd7) ? ONES : ZERO};
    endfunction

    assign sel  = (!pass && (op == 3'd0 || op == 3'd6)) ? bus.fk_r : bus.fk_q;
    assign last = pass || !op[2];
    assign mism = (bus.fk_p != fa) || ((bus.fk_q ^ bus.fk_r) != (fb ^ fc));

    always_comb begin
        state_n = state;
        op_n = op;
        a_n = a;
        b_n = b;
        pass_n = pass;
        cnt_n = cnt;
        err_n = err;
        {fa_n, fb_n, fc_n} = {fa, fb, fc};
        data_n = data;
        ec_n = err_count;
        case (state)
            IDLE: if (bus.req_valid && rdy) begin
                state_n = RUN;
                {op_n, a_n, b_n} = {bus.req_op, bus.req_a, bus.req_b};
                {fa_n, fb_n, fc_n} = operands(bus.req_op, 1'b0, bus.req_a, bus.req_b, bus.req_c, ZERO);
                pass_n = 1'b0;
                cnt_n = 4'd0;
                err_n = 1'b0;
            end
            RUN: if (cnt == LAST) begin
                err_n = err | mism;
                if (last) begin
                    data_n = sel;
                    state_n = RESP;
                end else begin
                    {fa_n, fb_n, fc_n} = operands(op, 1'b1, a, b, ZERO, sel);
                    pass_n = 1'b1;
                    cnt_n = 4'd0;
                end
            end else begin
                cnt_n = cnt + 4'd1;
            end
            RESP: if (bus.resp_ready) begin
                state_n = IDLE;
                {fa_n, fb_n, fc_n} = '0;
                ec_n = (err && err_count != 8'hff) ? err_count + 8'd1 : err_count;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op <= '0;
            a <= '0;
            b <= '0;
            pass <= 1'b0;
            cnt <= '0;
            err <= 1'b0;
            rdy <= 1'b0;
            {fa, fb, fc} <= '0;
            data <= '0;
            err_count <= '0;
        end else begin
            state <= state_n;
            op <= op_n;
            a <= a_n;
            b <= b_n;
            pass <= pass_n;
            cnt <= cnt_n;
            err <= err_n;
            rdy <= (state_n == IDLE);
            {fa, fb, fc} <= {fa_n, fb_n, fc_n};
            data <= data_n;
            err_count <= ec_n;
        end
    end

    assign bus.req_ready  = rdy;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = data;
    assign bus.resp_err   = err;
    assign bus.fk_a       = fa;
    assign bus.fk_b       = fb;
    assign bus.fk_c       = fc;
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_fredkin_alu_sequencer.sv
// tb_fredkin_alu_sequencer: directed vectors against a 2-cycle Fredkin array model with fault injection.
module tb_fredkin_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [7:0]  err_count;
    logic        fault = 1'b0;
    logic [31:0] da, db, dc;
    logic [31:0] fkc_log [0:15];
    int          checks = 0;
    int          failures = 0;

    fredkin_alu_sequencer_if #(.WIDTH(32)) bus ();

    fredkin_alu_sequencer #(.WIDTH(32), .FK_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // One register stage: outputs valid two edges after fk_* change
    always @(posedge clk) {da, db, dc} <= {bus.fk_a, bus.fk_b, bus.fk_c};
    assign bus.fk_p = da ^ {31'b0, fault && dc != 32'h0};
    assign bus.fk_q = (da & dc) | (~da & db);
    assign bus.fk_r = (da & db) | (~da & dc);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, b, c, exp,
                         input logic exp_err, input int exp_lat, input int hold, input logic quiet);
        int n;
        string t;
        t = $sformatf("op%0d", op);
        if (!quiet) chk({t, "_ready"}, 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        {bus.req_op, bus.req_a, bus.req_b, bus.req_c} = {op, a, b, c};
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        fkc_log[0] = bus.fk_c;
        n = 0;
        while (!bus.resp_valid && n < 15) begin
            @(posedge clk); #1;
            n++;
            fkc_log[n] = bus.fk_c;
            if (!quiet && !bus.resp_valid) chk({t, "_busy"}, 32'(busy), 1);
        end
        chk({t, "_lat"}, n, exp_lat);
        chk({t, "_data"}, bus.resp_data, exp);
        chk({t, "_err"}, 32'(bus.resp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            {bus.req_op, bus.req_a, bus.req_b} = {3'd1, 32'hdead_beef, 32'h1234_5678};
            @(posedge clk); #1;
            chk("hold_data", bus.resp_data, exp);
            chk("hold_valid", 32'(bus.resp_valid), 1);
            chk("hold_ready", 32'(bus.req_ready), 0);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        if (!quiet) begin
            chk({t, "_done_valid"}, 32'(bus.resp_valid), 0);
            chk({t, "_done_fka"}, bus.fk_a | bus.fk_b | bus.fk_c, 0);
        end
    endtask

    initial begin
        {bus.req_valid, bus.req_op, bus.req_a, bus.req_b, bus.req_c, bus.resp_ready} = '0;
        #3;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_valid", 32'(bus.resp_valid), 0);
        chk("rst_data", bus.resp_data, 0);
        chk("rst_fk", bus.fk_a | bus.fk_b | bus.fk_c, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_errcnt", 32'(err_count), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 1'b0, 2, 0, 1'b0);
        chk("and_fkc", fkc_log[1], 32'h0);
        do_op(3'd4, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h88888888, 1'b0, 4, 0, 1'b0);
        chk("xor_fkc_p1", fkc_log[2], 32'hEDCBA987);
        do_op(3'd3, 32'h55555555, 32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 1'b0, 2, 0, 1'b0);
        do_op(3'd2, 32'h0000FFFF, 32'h0, 32'h0, 32'hFFFF0000, 1'b0, 2, 0, 1'b0);
        do_op(3'd1, 32'h0F0F0000, 32'h000000F0, 32'h0, 32'h0F0F00F0, 1'b0, 2, 0, 1'b0);
        do_op(3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000000, 1'b0, 4, 0, 1'b0);
        do_op(3'd7, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 4, 0, 1'b0);
        do_op(3'd5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'hFFFFFFFF, 1'b0, 4, 0, 1'b0);
        do_op(3'd6, 32'hFF00FF00, 32'hF0F0F0F0, 32'h0, 32'h0FFF0FFF, 1'b0, 4, 0, 1'b0);
        chk("errcnt_clean", 32'(err_count), 0);

        fault = 1'b1;
        do_op(3'd4, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h88888888, 1'b1, 4, 0, 1'b0);
        chk("errcnt_one", 32'(err_count), 1);
        for (int i = 0; i < 300; i++)
            do_op(3'd4, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0, 32'h0FF00FF0, 1'b1, 4, 0, 1'b1);
        chk("errcnt_sat", 32'(err_count), 255);
        fault = 1'b0;

        do_op(3'd0, 32'h0000FFFF, 32'h00FF00FF, 32'h0, 32'h000000FF, 1'b0, 2, 5, 1'b0);

        bus.req_valid = 1'b1;
        {bus.req_op, bus.req_a, bus.req_b, bus.req_c} = {3'd7, 96'h0};
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("nor_in_p1_fkb", bus.fk_b, 32'hFFFFFFFF);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.resp_valid), 0);
        chk("arst_data", bus.resp_data, 0);
        chk("arst_fk", bus.fk_a | bus.fk_b | bus.fk_c, 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(bus.req_ready), 0);
        chk("arst_errcnt", 32'(err_count), 0);
        #12 rst_n = 1'b1;
        chk("rel_ready", 32'(bus.req_ready), 0);
        @(posedge clk); #1;
        do_op(3'd0, 32'h1, 32'h1, 32'h0, 32'h00000001, 1'b0, 2, 0, 1'b0);
        chk("final_errcnt", 32'(err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
